// File: rtl/data_ram_responder.sv
// Data-memory responder for the MEM stage: synchronous-read word RAM with byte-lane writes,
// a post-reset clear sequencer and a read-only debug port. Define DMEM_BYPASS_EN for write-first dm reads.
module data_ram_responder #(
  parameter int ADDR_W         = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dm_addr,
  input  logic [3:0]  dm_wen,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  input  logic [31:0] test_addr,
  output logic [31:0] test_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] test_idx;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       mem_word;
  logic [31:0]       rd_word;
  logic              unused_addr_bits;

  // Upper and byte-offset address bits are ignored, so addresses alias modulo the array size.
  assign idx      = dm_addr[ADDR_W+1:2];
  assign test_idx = test_addr[ADDR_W+1:2];
  assign mem_word = mem[idx];
  assign unused_addr_bits = ^{dm_addr[31:ADDR_W+2], dm_addr[1:0],
                              test_addr[31:ADDR_W+2], test_addr[1:0]};

  always_comb begin
    // NOTE: default assignment first so every path drives rd_word and no latch is inferred.
    rd_word = mem_word;
`ifdef DMEM_BYPASS_EN
    for (int i = 0; i < 4; i++) begin
      if (dm_wen[i]) rd_word[8*i +: 8] = dm_wdata[8*i +: 8];
    end
`endif
  end

  // NOTE: the array has no reset branch; zeroing is done one word per cycle by the clear sequence.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (dm_wen[i]) mem[idx][8*i +: 8] <= dm_wdata[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR_ON_RESET ? CLEAR : READY;
      dm_ready  <= !CLEAR_ON_RESET;
      clr_cnt   <= '0;
      dm_rdata  <= '0;
      test_data <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt   <= clr_cnt + ADDR_W'(1);
          dm_rdata  <= '0;
          test_data <= '0;
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            state    <= READY;
            dm_ready <= 1'b1;
          end
        end
        READY: begin
          // Test port is always read-first, independent of any dm-port write this cycle.
          dm_rdata  <= rd_word;
          test_data <= mem[test_idx];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// Self-checking bench for data_ram_responder: word-level reference model compared every cycle,
// plus directed vectors with hand-computed expectations.
module tb_data_ram_responder;

  logic        clk;
  logic        rst;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wen;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic [31:0] test_addr;
  logic [31:0] test_data;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  data_ram_responder dut (
    .clk       (clk),
    .rst       (rst),
    .dm_addr   (dm_addr),
    .dm_wen    (dm_wen),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .test_addr (test_addr),
    .test_data (test_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 256 words, zero after any reset once the clear window has elapsed.
  logic [31:0] m_mem [256];
  int          m_left;
  logic [31:0] exp_rdata;
  logic [31:0] exp_test;
  logic        exp_ready;

  always @(posedge clk) begin
    logic [31:0] old_w;
    logic [31:0] new_w;
    if (rst) begin
      m_left    = 256;
      exp_ready = 1'b0;
      exp_rdata = '0;
      exp_test  = '0;
      for (int k = 0; k < 256; k++) m_mem[k] = '0;
    end else if (m_left > 0) begin
      m_left--;
      exp_ready = (m_left == 0);
      exp_rdata = '0;
      exp_test  = '0;
    end else begin
      old_w = m_mem[dm_addr[9:2]];
      new_w = old_w;
      for (int i = 0; i < 4; i++)
        if (dm_wen[i]) new_w[8*i +: 8] = dm_wdata[8*i +: 8];
`ifdef DMEM_BYPASS_EN
      exp_rdata = new_w;
`else
      exp_rdata = old_w;
`endif
      exp_test = m_mem[test_addr[9:2]];
      m_mem[dm_addr[9:2]] = new_w;
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("cyc_dm_rdata", dm_rdata, exp_rdata);
      check("cyc_test_data", test_data, exp_test);
      check("cyc_dm_ready", {31'b0, dm_ready}, {31'b0, exp_ready});
    end
  end

  task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                        input logic [31:0] t);
    @(negedge clk);
    dm_addr   = a;
    dm_wen    = w;
    dm_wdata  = d;
    test_addr = t;
    @(posedge clk);
    #2;
  endtask

  // Counts clock edges from the current point until dm_ready is seen high, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (n < 1000) begin
      @(posedge clk);
      #2;
      n++;
      if (dm_ready === 1'b1) break;
    end
  endtask

  int n;

  initial begin
    rst = 1'b1; dm_addr = '0; dm_wen = '0; dm_wdata = '0; test_addr = '0;
    @(posedge clk);
    #2;
    cmp_en = 1'b1;
    check("rst_ready", {31'b0, dm_ready}, 32'd0);
    check("rst_rdata", dm_rdata, 32'h0);
    check("rst_test", test_data, 32'h0);

    // Initial clear, with a store held on the dm port that must be ignored.
    @(negedge clk);
    rst = 1'b0; dm_addr = 32'h20; dm_wen = 4'hF; dm_wdata = 32'hCAFEF00D;
    wait_ready(n);
    check("clear_len", n, 32'd256);

    access(32'h000, 4'h0, 32'h0, 32'h0);
    check("rd_0x000", dm_rdata, 32'h0);
    access(32'h3FC, 4'h0, 32'h0, 32'h0);
    check("rd_0x3FC", dm_rdata, 32'h0);
    access(32'h020, 4'h0, 32'h0, 32'h0);
    check("rd_0x020_clear_wr", dm_rdata, 32'h0);

    access(32'h10, 4'hF, 32'h12345678, 32'h0);
    access(32'h10, 4'h0, 32'h0, 32'h0);
    check("sw_rd", dm_rdata, 32'h12345678);

    access(32'h11, 4'b0010, 32'h0000AB00, 32'h0);
    access(32'h10, 4'h0, 32'h0, 32'h0);
    check("sb_rd", dm_rdata, 32'h1234AB78);

    // Debug port alongside dm stores, including same-word collision and aliasing.
    access(32'h40, 4'hF, 32'h55AA55AA, 32'h10);
    check("tp_0x10", test_data, 32'h1234AB78);
    access(32'h00, 4'h0, 32'h0, 32'h40);
    check("tp_0x40", test_data, 32'h55AA55AA);
    access(32'h40, 4'hF, 32'h11111111, 32'h40);
    check("tp_collide", test_data, 32'h55AA55AA);
`ifdef DMEM_BYPASS_EN
    check("dm_collide", dm_rdata, 32'h11111111);
`else
    check("dm_collide", dm_rdata, 32'h55AA55AA);
`endif
    access(32'h00, 4'h0, 32'h0, 32'h410);
    check("tp_alias", test_data, 32'h1234AB78);
    access(32'h412, 4'h0, 32'h0, 32'h0);
    check("dm_alias", dm_rdata, 32'h1234AB78);

    // Same-cycle write on the dm port: read-first vs merged write-first.
    access(32'h10, 4'b0001, 32'h000000EF, 32'h0);
`ifdef DMEM_BYPASS_EN
    check("same_sb", dm_rdata, 32'h1234ABEF);
`else
    check("same_sb", dm_rdata, 32'h1234AB78);
`endif
    access(32'h10, 4'hF, 32'hDEADBEEF, 32'h0);
`ifdef DMEM_BYPASS_EN
    check("same_sw", dm_rdata, 32'hDEADBEEF);
`else
    check("same_sw", dm_rdata, 32'h1234ABEF);
`endif
    access(32'h10, 4'h0, 32'h0, 32'h0);
    check("after_sw", dm_rdata, 32'hDEADBEEF);

    // Reset in READY, then a second reset pulse 100 cycles into the clear.
    @(negedge clk);
    rst = 1'b1; dm_addr = 32'h20; dm_wen = 4'hF; dm_wdata = 32'hBAADF00D;
    @(posedge clk);
    #2;
    check("rst2_ready", {31'b0, dm_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("rst3_ready", {31'b0, dm_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    check("reclear_len", n, 32'd256);
    access(32'h20, 4'h0, 32'h0, 32'h0);
    check("rd_0x20_zero", dm_rdata, 32'h0);
    access(32'h10, 4'h0, 32'h0, 32'h10);
    check("rd_0x10_zero", dm_rdata, 32'h0);
    check("tp_0x10_zero", test_data, 32'h0);

    // Store, then a reset whose rising cycle carries a store that must be dropped.
    access(32'h20, 4'hF, 32'hA5A5A5A5, 32'h0);
    access(32'h20, 4'h0, 32'h0, 32'h0);
    check("rd_0x20_a5", dm_rdata, 32'hA5A5A5A5);
    @(negedge clk);
    rst = 1'b1; dm_addr = 32'h30; dm_wen = 4'hF; dm_wdata = 32'h77777777;
    @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    check("reclear2_len", n, 32'd256);
    access(32'h20, 4'h0, 32'h0, 32'h30);
    check("rd_0x20_final", dm_rdata, 32'h0);
    check("tp_0x30_final", test_data, 32'h0);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
